// File: rtl/accel_sample_fifo.sv
// accel_sample_fifo
//   Periodically captures the accelerometer Y/Z pair into a circular FIFO so
//   firmware reads a time-ordered sample stream over the picorv32 look-ahead
//   bus. A level IRQ is raised while the fill level is at or above a
//   programmable threshold.
//
// Ports
//   clk           system clock, all logic on posedge
//   resetn        asynchronous active-low reset
//   y_value       Y sample from accelerometer_reader
//   z_value       Z sample from accelerometer_reader
//   mem_la_read   CPU look-ahead read strobe
//   mem_la_write  CPU look-ahead write strobe
//   mem_la_addr   CPU look-ahead address
//   mem_la_wdata  CPU look-ahead write data
//   rdata         registered read data, valid the cycle after a read strobe
//   rdata_hit     one-cycle pulse marking rdata as belonging to this block
//   irq           level interrupt request
//
// Register window (offsets from BASE_ADDR)
//   0x0 DATA   R  : {z, y} of oldest entry, read pops; empty reads 0
//   0x4 STATUS R  : {16'b0, count, 5'b0, overflow, full, empty}
//   0x8 CTRL   RW : bit0 enable, bit1 irq_en, bits[15:8] threshold
//   0xC CLEAR  W  : bit0 flush FIFO, bit1 clear overflow; reads 0
module accel_sample_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] y_value,
  input  logic [15:0] z_value,
  input  logic        mem_la_read,
  input  logic        mem_la_write,
  input  logic [31:0] mem_la_addr,
  input  logic [31:0] mem_la_wdata,
  output logic [31:0] rdata,
  output logic        rdata_hit,
  output logic        irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [31:0] ADDR_DATA   = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_CLEAR  = BASE_ADDR + 32'hC;

  // Bus handshake: a strobe (mem_la_read / mem_la_write) is a single-cycle
  // request with no back-pressure; it is accepted on the posedge where it is
  // high. Reads answer with rdata/rdata_hit registered on that same edge, so
  // they are visible for exactly the following cycle. Writes update state on
  // that same edge. Only exact matches on the four word addresses decode.
  logic rd_data, rd_status, rd_ctrl, rd_clear, rd_hit;
  logic wr_ctrl, wr_clear;

  assign rd_data   = mem_la_read  && (mem_la_addr == ADDR_DATA);
  assign rd_status = mem_la_read  && (mem_la_addr == ADDR_STATUS);
  assign rd_ctrl   = mem_la_read  && (mem_la_addr == ADDR_CTRL);
  assign rd_clear  = mem_la_read  && (mem_la_addr == ADDR_CLEAR);
  assign rd_hit    = rd_data || rd_status || rd_ctrl || rd_clear;
  assign wr_ctrl   = mem_la_write && (mem_la_addr == ADDR_CTRL);
  assign wr_clear  = mem_la_write && (mem_la_addr == ADDR_CLEAR);

  logic          enable;
  logic          irq_en;
  logic [7:0]    threshold;
  logic [DW-1:0] divider;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   mem [DEPTH];

  logic [7:0] count8;
  logic       empty, full;
  logic       push, pop, flush, ovf_clr;
  logic       do_push, do_pop, ovf_set;
  logic [31:0] read_word;

  assign count8 = 8'(count);
  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);

  assign push    = enable && (divider == DIV_LAST);
  assign pop     = rd_data && !empty;
  assign flush   = wr_clear && mem_la_wdata[0];
  assign ovf_clr = wr_clear && mem_la_wdata[1];

  // A flush discards any same-cycle push. A push into a full FIFO is only
  // lost when no pop frees the slot in the same cycle.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush;
  assign ovf_set = push && !flush && full && !pop;

  // Write-data bits with no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^{mem_la_wdata[31:16], mem_la_wdata[7:2]};

  // STATUS reflects the registered count, i.e. the value before any
  // push/pop happening on the same edge.
  always_comb begin
    read_word = 32'h0;
    if (rd_data) begin
      read_word = empty ? 32'h0 : mem[rd_ptr];
    end else if (rd_status) begin
      read_word = {16'h0, count8, 5'b0, overflow, full, empty};
    end else if (rd_ctrl) begin
      read_word = {16'h0, threshold, 6'b0, irq_en, enable};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata     <= 32'h0;
      rdata_hit <= 1'b0;
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= 8'h0;
      divider   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      rdata     <= read_word;
      rdata_hit <= rd_hit;

      if (wr_ctrl) begin
        enable    <= mem_la_wdata[0];
        irq_en    <= mem_la_wdata[1];
        threshold <= mem_la_wdata[15:8];
      end

      // Divider is parked at 0 while disabled so the first sample lands a
      // full SAMPLE_DIV cycles after enabling.
      if (!enable) begin
        divider <= '0;
      end else if (divider == DIV_LAST) begin
        divider <= '0;
      end else begin
        divider <= divider + DW'(1);
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (do_push && !do_pop) begin
          count <= count + CW'(1);
        end else if (do_pop && !do_push) begin
          count <= count - CW'(1);
        end
      end

      // Clear beats a same-cycle set.
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end

      irq <= irq_en && (threshold != 8'h0) && (count8 >= threshold);
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {z_value, y_value};
  end

endmodule

// File: tb/tb_accel_sample_fifo.sv
// tb_accel_sample_fifo
//   Directed bench for accel_sample_fifo with DEPTH=16, SAMPLE_DIV=4.
//   Inputs change just after the falling edge; outputs are sampled on the
//   falling edge, half a cycle after the rising edge that produced them.
module tb_accel_sample_fifo;

  localparam logic [31:0] A_DATA   = 32'h4000_0000;
  localparam logic [31:0] A_STATUS = 32'h4000_0004;
  localparam logic [31:0] A_CTRL   = 32'h4000_0008;
  localparam logic [31:0] A_CLEAR  = 32'h4000_000C;

  logic        clk;
  logic        resetn;
  logic [15:0] y_value;
  logic [15:0] z_value;
  logic        mem_la_read;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [31:0] rdata;
  logic        rdata_hit;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  accel_sample_fifo #(
    .DEPTH      (16),
    .SAMPLE_DIV (4),
    .BASE_ADDR  (32'h4000_0000)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .y_value      (y_value),
    .z_value      (z_value),
    .mem_la_read  (mem_la_read),
    .mem_la_write (mem_la_write),
    .mem_la_addr  (mem_la_addr),
    .mem_la_wdata (mem_la_wdata),
    .rdata        (rdata),
    .rdata_hit    (rdata_hit),
    .irq          (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_la_addr  = a;
    mem_la_wdata = d;
    mem_la_write = 1'b1;
    @(negedge clk);
    mem_la_write = 1'b0;
    mem_la_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    mem_la_addr = a;
    mem_la_read = 1'b1;
    @(negedge clk);
    mem_la_read = 1'b0;
    d = rdata;
    h = rdata_hit;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    bus_read(a, d, h);
    check(tag, d, exp);
    check({tag, "_hit"}, {31'b0, h}, 32'h1);
  endtask

  // Pops the scoreboard; an empty FIFO must read 0.
  task automatic read_data(input string tag);
    logic [31:0] d;
    logic        h;
    logic [31:0] e;
    e = 32'h0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    bus_read(A_DATA, d, h);
    check(tag, d, e);
    check({tag, "_hit"}, {31'b0, h}, 32'h1);
  endtask

  // Must start right after the enabling write lands (divider at 0): each
  // loop pass covers exactly one sample period, ending on its push edge.
  task automatic run_samples(input int n, input logic [15:0] yb, input logic [15:0] zb);
    for (int i = 0; i < n; i++) begin
      y_value = yb + 16'(i);
      z_value = zb + 16'(i);
      if (exp_q.size() < 16) exp_q.push_back({z_value, y_value});
      repeat (4) @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic        h;

    resetn       = 1'b0;
    y_value      = 16'h0;
    z_value      = 16'h0;
    mem_la_read  = 1'b0;
    mem_la_write = 1'b0;
    mem_la_addr  = 32'h0;
    mem_la_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_hit", {31'b0, rdata_hit}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    check_reg("rst_status", A_STATUS, 32'h0000_0001);
    check_reg("rst_ctrl", A_CTRL, 32'h0);
    check_reg("clear_reads0", A_CLEAR, 32'h0);
    bus_read(A_CTRL + 32'h10, d, h);
    check("decode_out_hit", {31'b0, h}, 32'h0);
    bus_read(A_DATA + 32'h1, d, h);
    check("decode_unaligned_hit", {31'b0, h}, 32'h0);

    // 1: single sample
    y_value = 16'h0012;
    z_value = 16'hFF34;
    bus_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    check_reg("t1_status_pre", A_STATUS, 32'h0000_0001);  // read on push edge
    exp_q.push_back(32'hFF34_0012);
    bus_write(A_CTRL, 32'h0);
    check_reg("t1_status_one", A_STATUS, 32'h0000_0100);
    read_data("t1_data");
    @(negedge clk);
    check("t1_hit_pulse", {31'b0, rdata_hit}, 32'h0);
    check_reg("t1_status_empty", A_STATUS, 32'h0000_0001);

    // 2: 17 samples into 16 entries
    bus_write(A_CTRL, 32'h1);
    run_samples(17, 16'h0100, 16'hA000);
    bus_write(A_CTRL, 32'h0);
    check_reg("t2_status_full", A_STATUS, 32'h0000_1006);
    bus_write(A_CLEAR, 32'h2);
    check_reg("t2_status_ovfclr", A_STATUS, 32'h0000_1002);

    // 3: DATA read on the push edge of a full FIFO
    y_value = 16'h5A5A;
    z_value = 16'hC3C3;
    bus_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    read_data("t3_oldest");
    exp_q.push_back(32'hC3C3_5A5A);
    bus_write(A_CTRL, 32'h0);
    check_reg("t3_status", A_STATUS, 32'h0000_1002);
    for (int i = 0; i < 16; i++) read_data($sformatf("t2_data%0d", i));
    check_reg("t2_status_empty", A_STATUS, 32'h0000_0001);
    read_data("t2_empty_read");

    // 4: threshold irq
    bus_write(A_CTRL, 32'h0000_0403);
    run_samples(4, 16'h0200, 16'hB000);
    check("t4_irq_not_yet", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("t4_irq_rise", {31'b0, irq}, 32'h1);
    bus_write(A_CTRL, 32'h0000_0402);
    read_data("t4_data");
    check("t4_irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("t4_irq_fall", {31'b0, irq}, 32'h0);
    check_reg("t4_ctrl", A_CTRL, 32'h0000_0402);

    // 5: flush / overflow-clear precedence, then CLEAR=3
    bus_write(A_CLEAR, 32'h1);
    exp_q.delete();
    check_reg("t5_flush_empty", A_STATUS, 32'h0000_0001);
    bus_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    bus_write(A_CLEAR, 32'h1);  // lands on push edge
    bus_write(A_CTRL, 32'h0);
    check_reg("t5_flush_wins", A_STATUS, 32'h0000_0001);
    bus_write(A_CTRL, 32'h1);
    run_samples(16, 16'h0300, 16'hD000);
    repeat (3) @(negedge clk);
    bus_write(A_CLEAR, 32'h2);  // lands on the dropped 17th push
    bus_write(A_CTRL, 32'h0);
    check_reg("t5_clr_wins", A_STATUS, 32'h0000_1002);
    bus_write(A_CTRL, 32'h1);
    run_samples(1, 16'h0400, 16'hE000);
    bus_write(A_CTRL, 32'h0);
    check_reg("t5_ovf_set", A_STATUS, 32'h0000_1006);
    for (int i = 0; i < 11; i++) read_data($sformatf("t5_data%0d", i));
    check_reg("t5_count5", A_STATUS, 32'h0000_0504);
    bus_write(A_CLEAR, 32'h3);
    exp_q.delete();
    check_reg("t5_cleared", A_STATUS, 32'h0000_0001);
    read_data("t5_empty_read");

    // 6: async reset mid-operation
    bus_write(A_CTRL, 32'h0000_0703);
    run_samples(7, 16'h0500, 16'hF000);
    check_reg("t6_status7", A_STATUS, 32'h0000_0700);
    check("t6_irq_on", {31'b0, irq}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_hit", {31'b0, rdata_hit}, 32'h0);
    check("t6_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reg("t6_ctrl", A_CTRL, 32'h0);
    check_reg("t6_status", A_STATUS, 32'h0000_0001);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
